// File: rtl/vdc_out_pkg.sv
// VDC video output stage: shared constants.
// RGBI bit positions, the fixed 16-entry palette and the brown test.
package vdc_out_pkg;

    localparam int RGBI_R = 3;
    localparam int RGBI_G = 2;
    localparam int RGBI_B = 1;
    localparam int RGBI_I = 0;

    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'h555555, 24'h0000AA, 24'h5555FF,
        24'h00AA00, 24'h55FF55, 24'h00AAAA, 24'h55FFFF,
        24'hAA0000, 24'hFF5555, 24'hAA00AA, 24'hFF55FF,
        24'hAA5500, 24'hFFFF55, 24'hAAAAAA, 24'hFFFFFF
    };

    // Colour used for index 12 when the brown fix is disabled.
    localparam logic [23:0] DARK_YELLOW = 24'hAAAA00;

    // Index 12: red and green set, blue and intensity clear.
    function automatic logic is_brown(input logic [3:0] idx);
        return idx[RGBI_R] & idx[RGBI_G] & ~idx[RGBI_B] & ~idx[RGBI_I];
    endfunction

endpackage

// File: rtl/vdc_sync_polarity.sv
// Sync polarity detector: times the high and low phases of a sync input
// and reports it as inverted when the high phase is the longer one.
module vdc_sync_polarity #(
    parameter int CNT_BITS = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_en,
    input  logic count_en,
    input  logic sync,
    output logic inv
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic                prev;
    logic                edge_s;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] hi_dur;
    logic [CNT_BITS-1:0] lo_dur;
    logic                hi_ok;
    logic                lo_ok;
    logic [CNT_BITS-1:0] hi_nxt;
    logic [CNT_BITS-1:0] lo_nxt;
    logic                hi_ok_nxt;
    logic                lo_ok_nxt;

    assign edge_s = sample_en && (sync != prev);

    // Latch the length of the phase that ends on this edge.
    always_comb begin
        hi_nxt    = hi_dur;
        lo_nxt    = lo_dur;
        hi_ok_nxt = hi_ok;
        lo_ok_nxt = lo_ok;
        if (edge_s) begin
            if (prev) begin
                hi_nxt    = cnt;
                hi_ok_nxt = 1'b1;
            end else begin
                lo_nxt    = cnt;
                lo_ok_nxt = 1'b1;
            end
        end
    end

    // Phase counter, duration latches and polarity decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev   <= 1'b0;
            cnt    <= '0;
            hi_dur <= '0;
            lo_dur <= '0;
            hi_ok  <= 1'b0;
            lo_ok  <= 1'b0;
            inv    <= 1'b0;
        end else begin
            if (sample_en) prev <= sync;
            if (edge_s) begin
                cnt <= count_en ? CNT_ONE : '0;
            end else if (count_en && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end
            hi_dur <= hi_nxt;
            lo_dur <= lo_nxt;
            hi_ok  <= hi_ok_nxt;
            lo_ok  <= lo_ok_nxt;
            if (edge_s && hi_ok_nxt && lo_ok_nxt && hi_nxt != lo_nxt) begin
                inv <= hi_nxt > lo_nxt;
            end
        end
    end

endmodule

// File: rtl/vdc_video_out.sv
// VDC video output stage: palette expansion, sync polarity normalisation
// and line/frame length measurement, one clock behind the core.
module vdc_video_out #(
    parameter bit BROWN_FIX = 1'b1,
    parameter int CNT_BITS  = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pixelclk,
    input  logic [3:0]          rgbi,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                hblank_in,
    input  logic                vblank_in,
    input  logic                field_in,
    output logic                ce_pix,
    output logic [7:0]          r,
    output logic [7:0]          g,
    output logic [7:0]          b,
    output logic                hs,
    output logic                vs,
    output logic                hb,
    output logic                vb,
    output logic                fld,
    output logic                hs_inv,
    output logic                vs_inv,
    output logic [CNT_BITS-1:0] line_pix,
    output logic [CNT_BITS-1:0] frame_lines
);

    import vdc_out_pkg::*;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic                hs_now;
    logic                vs_now;
    logic                hs_rise;
    logic                vs_rise;
    logic [23:0]         rgb_nxt;
    logic [CNT_BITS-1:0] pix_cnt;
    logic [CNT_BITS-1:0] line_cnt;
    logic [CNT_BITS-1:0] line_inc;
    logic                line_ok;
    logic                frame_ok;

    assign hs_now  = hsync_in ^ hs_inv;
    assign vs_now  = vsync_in ^ vs_inv;
    assign hs_rise = pixelclk & hs_now & ~hs;
    assign vs_rise = pixelclk & vs_now & ~vs;

    assign line_inc = (hs_rise && line_cnt != CNT_MAX) ? line_cnt + CNT_ONE
                                                       : line_cnt;

    vdc_sync_polarity #(.CNT_BITS(CNT_BITS)) u_hpol (
        .clk       (clk),
        .reset     (reset),
        .sample_en (pixelclk),
        .count_en  (pixelclk),
        .sync      (hsync_in),
        .inv       (hs_inv)
    );

    // Vertical phases are measured in lines, not pixels.
    vdc_sync_polarity #(.CNT_BITS(CNT_BITS)) u_vpol (
        .clk       (clk),
        .reset     (reset),
        .sample_en (pixelclk),
        .count_en  (hs_rise),
        .sync      (vsync_in),
        .inv       (vs_inv)
    );

    // Palette lookup with blanking forced to black.
    always_comb begin
        rgb_nxt = PALETTE[rgbi];
        if (!BROWN_FIX && is_brown(rgbi)) rgb_nxt = DARK_YELLOW;
        if (hblank_in || vblank_in) rgb_nxt = '0;
    end

    // Output alignment register, advanced only on pixel enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_pix <= 1'b0;
            r      <= '0;
            g      <= '0;
            b      <= '0;
            hs     <= 1'b0;
            vs     <= 1'b0;
            hb     <= 1'b0;
            vb     <= 1'b0;
            fld    <= 1'b0;
        end else begin
            ce_pix <= pixelclk;
            if (pixelclk) begin
                {r, g, b} <= rgb_nxt;
                hs        <= hs_now;
                vs        <= vs_now;
                hb        <= hblank_in;
                vb        <= vblank_in;
                fld       <= field_in;
            end
        end
    end

    // Line length in pixels and frame height in lines, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt     <= '0;
            line_cnt    <= '0;
            line_ok     <= 1'b0;
            frame_ok    <= 1'b0;
            line_pix    <= '0;
            frame_lines <= '0;
        end else if (pixelclk) begin
            if (hs_rise) begin
                if (line_ok) line_pix <= pix_cnt;
                line_ok <= 1'b1;
                pix_cnt <= CNT_ONE;
            end else if (pix_cnt != CNT_MAX) begin
                pix_cnt <= pix_cnt + CNT_ONE;
            end
            if (vs_rise) begin
                if (frame_ok) frame_lines <= line_inc;
                frame_ok <= 1'b1;
                line_cnt <= '0;
            end else begin
                line_cnt <= line_inc;
            end
        end
    end

endmodule

// File: tb/tb_vdc_video_out.sv
// Directed bench for vdc_video_out: palette, blanking, freeze, sync
// polarity, line/frame measurement, saturation and mid-frame reset.
module tb_vdc_video_out;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixelclk;
    logic [3:0]  rgbi;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblank_in;
    logic        vblank_in;
    logic        field_in;

    logic        ce_pix;
    logic [7:0]  r, g, b;
    logic        hs, vs, hb, vb, fld, hs_inv, vs_inv;
    logic [11:0] line_pix;
    logic [11:0] frame_lines;

    logic        ce_pix_a;
    logic [7:0]  r_a, g_a, b_a;
    logic        hs_a, vs_a, hb_a, vb_a, fld_a, hs_inv_a, vs_inv_a;
    logic [11:0] line_pix_a;
    logic [11:0] frame_lines_a;

    int total = 0;
    int bad   = 0;
    logic [23:0] exp_pal [16];

    always #5 clk = ~clk;

    vdc_video_out #(.BROWN_FIX(1'b1), .CNT_BITS(12)) dut (
        .clk(clk), .reset(reset), .pixelclk(pixelclk), .rgbi(rgbi),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblank_in(hblank_in), .vblank_in(vblank_in),
        .field_in(field_in), .ce_pix(ce_pix),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .hb(hb), .vb(vb),
        .fld(fld), .hs_inv(hs_inv), .vs_inv(vs_inv),
        .line_pix(line_pix), .frame_lines(frame_lines)
    );

    vdc_video_out #(.BROWN_FIX(1'b0), .CNT_BITS(12)) dut_alt (
        .clk(clk), .reset(reset), .pixelclk(pixelclk), .rgbi(rgbi),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblank_in(hblank_in), .vblank_in(vblank_in),
        .field_in(field_in), .ce_pix(ce_pix_a),
        .r(r_a), .g(g_a), .b(b_a), .hs(hs_a), .vs(vs_a), .hb(hb_a),
        .vb(vb_a), .fld(fld_a), .hs_inv(hs_inv_a), .vs_inv(vs_inv_a),
        .line_pix(line_pix_a), .frame_lines(frame_lines_a)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic pix(input logic [3:0] c, input logic hsi,
                       input logic vsi, input logic hbi, input logic vbi);
        rgbi      = c;
        hsync_in  = hsi;
        vsync_in  = vsi;
        hblank_in = hbi;
        vblank_in = vbi;
        pixelclk  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic hline(input int lo, input int hi, input logic va,
                         input logic vz, input int vpos);
        for (int i = 0; i < lo + hi; i++)
            pix(4'd0, i >= lo, (i < vpos) ? va : vz, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pixelclk = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rgb"}, {8'h0, r, g, b}, 32'h0);
        chk({tag, "_ctl"},
            {24'h0, ce_pix, hs, vs, hb, vb, fld, hs_inv, vs_inv}, 32'h0);
        chk({tag, "_lpix"}, {20'h0, line_pix}, 32'h0);
        chk({tag, "_flines"}, {20'h0, frame_lines}, 32'h0);
    endtask

    initial begin
        int hcnt;
        exp_pal = '{
            24'h000000, 24'h555555, 24'h0000AA, 24'h5555FF,
            24'h00AA00, 24'h55FF55, 24'h00AAAA, 24'h55FFFF,
            24'hAA0000, 24'hFF5555, 24'hAA00AA, 24'hFF55FF,
            24'hAA5500, 24'hFFFF55, 24'hAAAAAA, 24'hFFFFFF
        };
        reset     = 1'b1;
        pixelclk  = 1'b0;
        rgbi      = 4'h0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblank_in = 1'b0;
        vblank_in = 1'b0;
        field_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // palette sweep
        for (int i = 0; i < 16; i++) begin
            pix(i[3:0], 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("pal%0d", i), {8'h0, r, g, b}, {8'h0, exp_pal[i]});
            if (i == 12)
                chk("pal12_alt", {8'h0, r_a, g_a, b_a}, 32'h00AAAA00);
        end
        chk("ce_on", {31'h0, ce_pix}, 32'h1);

        field_in = 1'b1;
        pix(4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fld", {31'h0, fld}, 32'h1);
        field_in = 1'b0;

        // blanking
        pix(4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hblank_rgb", {8'h0, r, g, b}, 32'h0);
        chk("hblank_hb", {30'h0, hb, vb}, 32'h2);
        chk("hblank_ce", {31'h0, ce_pix}, 32'h1);
        pixelclk = 1'b0;
        @(posedge clk);
        #1;
        chk("ce_off", {31'h0, ce_pix}, 32'h0);
        pix(4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("vblank_rgb", {8'h0, r, g, b}, 32'h0);
        chk("vblank_vb", {30'h0, hb, vb}, 32'h1);

        // freeze with pixelclk low
        pix(4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        pixelclk  = 1'b0;
        rgbi      = 4'd3;
        hblank_in = 1'b1;
        field_in  = 1'b1;
        vsync_in  = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("frz_rgb", {8'h0, r, g, b}, 32'h00FF5555);
        chk("frz_ctl", {26'h0, ce_pix, hs, vs, hb, vb, fld}, 32'h0);
        hblank_in = 1'b0;
        field_in  = 1'b0;
        vsync_in  = 1'b0;

        // hsync active-low: low 9, high 117
        do_reset();
        hline(9, 117, 1'b0, 1'b0, 0);
        chk("hinv_1edge", {31'h0, hs_inv}, 32'h0);
        hline(9, 117, 1'b0, 1'b0, 0);
        chk("hinv_2edge", {31'h0, hs_inv}, 32'h1);
        hcnt = 0;
        for (int i = 0; i < 126; i++) begin
            pix(4'd0, i >= 9, 1'b0, 1'b0, 1'b0);
            if (hs) hcnt++;
        end
        chk("hs_width", hcnt, 32'd9);
        hline(9, 117, 1'b0, 1'b0, 0);
        chk("line_126", {20'h0, line_pix}, 32'd126);

        // saturation with a 5000 pixel gap between hsyncs
        do_reset();
        repeat (3) pix(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pix(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5000) pix(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pix(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_line", {20'h0, line_pix}, 32'd4095);
        chk("sat_hs", {31'h0, hs}, 32'h1);
        repeat (999) pix(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        pix(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_inv", {31'h0, hs_inv}, 32'h0);

        // frame: 127 pixel lines, 312 lines, vsync active-low
        vsync_in = 1'b1;
        do_reset();
        for (int l = 0; l < 6; l++) hline(9, 118, 1'b1, 1'b1, 50);
        hline(9, 118, 1'b1, 1'b0, 50);
        hline(9, 118, 1'b0, 1'b0, 50);
        chk("vs_active", {30'h0, vs, vs_inv}, 32'h3);
        hline(9, 118, 1'b0, 1'b0, 50);
        hline(9, 118, 1'b0, 1'b1, 50);
        for (int l = 10; l < 318; l++) hline(9, 118, 1'b1, 1'b1, 50);
        hline(9, 118, 1'b1, 1'b0, 50);
        chk("frame_312", {20'h0, frame_lines}, 32'd312);
        chk("line_127", {20'h0, line_pix}, 32'd127);
        chk("vinv_final", {30'h0, hs_inv, vs_inv}, 32'h3);

        // reset mid-frame
        pix(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst", {7'h0, hs, r, g, b}, 32'h01FFFFFF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
